// File: rtl/sc_inference_ctrl.sv
// sc_inference_ctrl: sequences one stochastic-computing inference pass (clear, stream, popcount, argmax).
// Define SC_CTRL_SCORE_OUT_EN to export every per-class popcount on score_flat.
module sc_inference_ctrl #(
    parameter int N2       = 10,
    parameter int LMAX     = 1024,
    parameter int LW       = 11,
    parameter int CW       = 11,
    parameter int PIPE_LAT = 2,
    parameter int IW       = $clog2(N2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LW-1:0]       len,
    input  logic                abort,
    output logic                busy,
    output logic                net_rst,
    output logic                sng_en,
    input  logic [N2-1:0]       net_dout,
    output logic [IW-1:0]       result_class,
    output logic [CW-1:0]       result_score,
    output logic                result_valid,
`ifdef SC_CTRL_SCORE_OUT_EN
    output logic [N2*CW-1:0]    score_flat,
`endif
    input  logic                result_ready
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, ARGMAX, DONE} state_t;
    localparam logic [LW:0]   PL       = (LW+1)'(PIPE_LAT);
    localparam logic [LW-1:0] LM       = LW'(LMAX);
    localparam logic [IW-1:0] LAST_IDX = IW'(N2-1);
    state_t        r_state;
    logic [LW-1:0] r_len;
    logic [LW:0]   r_cyc;
    logic [IW-1:0] r_idx, r_best_idx;
    logic [CW-1:0] r_best;
    logic [CW-1:0] r_cnt [N2];
    logic [LW:0]   w_cyc_nx;
    logic          w_run_last, w_take, w_abort;
    logic [CW-1:0] w_best;
    logic [IW-1:0] w_best_idx;

    always_comb begin
        w_cyc_nx   = r_cyc + 1'b1;
        w_run_last = w_cyc_nx == {1'b0, r_len} + PL;
        w_take     = r_idx == '0 || r_cnt[r_idx] > r_best;
        w_best     = w_take ? r_cnt[r_idx] : r_best;
        w_best_idx = w_take ? r_idx : r_best_idx;
        w_abort    = abort && (r_state == CLEAR || r_state == RUN || r_state == ARGMAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            busy         <= 1'b0;
            net_rst      <= 1'b1;
            sng_en       <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_score <= '0;
            r_len        <= '0;
            r_cyc        <= '0;
            r_idx        <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            for (int k = 0; k < N2; k++) r_cnt[k] <= '0;
`ifdef SC_CTRL_SCORE_OUT_EN
            score_flat   <= '0;
`endif
        end else if (w_abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            net_rst <= 1'b1;
            sng_en  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_len   <= len > LM ? LM : len;
                    r_state <= CLEAR;
                    busy    <= 1'b1;
                end
                CLEAR: begin
                    r_cyc <= '0;
                    r_idx <= '0;
                    for (int k = 0; k < N2; k++) r_cnt[k] <= '0;
                    r_state <= r_len == '0 ? ARGMAX : RUN;
                    net_rst <= r_len == '0;
                    sng_en  <= r_len != '0;
                end
                RUN: begin
                    r_cyc  <= w_cyc_nx;
                    sng_en <= w_cyc_nx < {1'b0, r_len};
                    // Bits reach net_dout PIPE_LAT cycles after the matching sng_en cycle.
                    if (r_cyc >= PL)
                        for (int k = 0; k < N2; k++)
                            if (net_dout[k] && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + 1'b1;
                    if (w_run_last) begin
                        r_state <= ARGMAX;
                        net_rst <= 1'b1;
                        sng_en  <= 1'b0;
                    end
                end
                ARGMAX: begin
                    r_idx      <= r_idx == LAST_IDX ? '0 : r_idx + 1'b1;
                    r_best     <= w_best;
                    r_best_idx <= w_best_idx;
                    if (r_idx == LAST_IDX) begin
                        r_state      <= DONE;
                        result_valid <= 1'b1;
                        result_class <= w_best_idx;
                        result_score <= w_best;
`ifdef SC_CTRL_SCORE_OUT_EN
                        for (int k = 0; k < N2; k++) score_flat[k*CW +: CW] <= r_cnt[k];
`endif
                    end
                end
                DONE: if (result_ready) begin
                    r_state      <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_inference_ctrl.sv
// tb_sc_inference_ctrl: table-driven passes against a cycle-level network output model, with scoreboard.
module tb_sc_inference_ctrl;
    localparam int N2 = 10, LW = 11, CW = 11, IW = 4;
    typedef struct {
        int len;
        int mode;
        int cls;
        int exp_cls;
        int exp_score;
        int exp_sng;
        int exp_lat;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, result_ready = 1'b0;
    logic [LW-1:0] len = '0;
    logic [N2-1:0] net_dout = '1;
    logic busy, net_rst, sng_en, result_valid;
    logic [IW-1:0] result_class;
    logic [CW-1:0] result_score;
`ifdef SC_CTRL_SCORE_OUT_EN
    logic [N2*CW-1:0] score_flat;
`endif
    int n_cmp = 0, n_bad = 0, mode = 0, cls_sel = 0, jj = 0, n_sng = 0, n_rv = 0;
    logic h1 = 1'b0, h2 = 1'b0, hv = 1'b0;
    vec_t sb[$];
    vec_t tbl[9];

    sc_inference_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
        .busy(busy), .net_rst(net_rst), .sng_en(sng_en), .net_dout(net_dout),
        .result_class(result_class), .result_score(result_score), .result_valid(result_valid),
`ifdef SC_CTRL_SCORE_OUT_EN
        .score_flat(score_flat),
`endif
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [N2-1:0] pat(input int m, input int j, input int c);
        logic [N2-1:0] p = '0;
        for (int k = 0; k < N2; k++)
            case (m)
                0: p[k] = (k == c);
                1: p[k] = (j % 2 == 0) ? (k == 2) : (k == 7);
                2: p[k] = 1'b1;
                4: p[k] = (k == 9) || (k == 4 && j < 3);
                5: p[k] = (j < k);
                default: p[k] = (j >= k);
            endcase
        return p;
    endfunction

    // Network model: a bit appears PIPE_LAT=2 cycles after its sng_en cycle; all-ones elsewhere.
    always @(negedge clk) begin
        hv = h2;
        h2 = h1;
        h1 = sng_en;
        if (sng_en) n_sng++;
        net_dout = hv ? pat(mode, jj, cls_sel) : '1;
        if (hv) jj++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_busy", int'(busy), 0);
        chk("rst_net_rst", int'(net_rst), 1);
        chk("rst_sng_en", int'(sng_en), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_class", int'(result_class), 0);
        chk("rst_score", int'(result_score), 0);
`ifdef SC_CTRL_SCORE_OUT_EN
        chk("rst_flat", int'(score_flat == '0), 1);
`endif
    endtask

    task automatic run_pass(input vec_t v, input int stall);
        int k = 0;
        vec_t e;
        mode = v.mode;
        cls_sel = v.cls;
        jj = 0;
        n_sng = 0;
        sb.push_back(v);
        len = LW'(v.len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_clear", int'(busy), 1);
        chk("netrst_clear", int'(net_rst), 1);
        while (!result_valid && k < v.exp_lat + 50) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("netrst_run0", int'(net_rst), v.exp_sng > 0 ? 0 : 1);
                chk("sng_run0", int'(sng_en), v.exp_sng > 0 ? 1 : 0);
            end
        end
        e = sb.pop_front();
        chk("valid_seen", int'(result_valid), 1);
        if (!result_valid) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        chk("latency", k, e.exp_lat);
        chk("class", int'(result_class), e.exp_cls);
        chk("score", int'(result_score), e.exp_score);
        chk("sng_cycles", n_sng, e.exp_sng);
        chk("net_rst_done", int'(net_rst), 1);
`ifdef SC_CTRL_SCORE_OUT_EN
        if (e.len == 16 && e.mode == 0 && e.cls == 3)
            for (int s = 0; s < N2; s++) chk("score_flat", int'(score_flat[s*CW +: CW]), s == 3 ? 16 : 0);
`endif
        start = stall > 0;
        abort = stall > 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(result_valid), 1);
            chk("hold_class", int'(result_class), e.exp_cls);
            chk("hold_score", int'(result_score), e.exp_score);
        end
        start = 1'b0;
        abort = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("valid_drop", int'(result_valid), 0);
        chk("busy_drop", int'(busy), 0);
        chk("class_kept", int'(result_class), e.exp_cls);
        @(negedge clk);
        chk("idle_stays", int'(busy), 0);
    endtask

    initial begin
        tbl[0] = '{16,   0, 3, 3, 16,   16,   29};
        tbl[1] = '{16,   1, 0, 2, 8,    16,   29};
        tbl[2] = '{2047, 2, 0, 0, 1024, 1024, 1037};
        tbl[3] = '{0,    0, 3, 0, 0,    0,    11};
        tbl[4] = '{5,    4, 0, 9, 5,    5,    18};
        tbl[5] = '{1,    0, 7, 7, 1,    1,    14};
        tbl[6] = '{10,   5, 0, 9, 9,    10,   23};
        tbl[7] = '{12,   6, 0, 0, 12,   12,   25};
        tbl[8] = '{1025, 0, 5, 5, 1024, 1024, 1037};
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) run_pass(tbl[i], 0);
        // start with abort in IDLE is accepted; abort in RUN cycle 5 discards the pass
        mode = 0;
        cls_sel = 3;
        jj = 0;
        len = LW'(16);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_ignored_idle", int'(busy), 1);
        repeat (6) @(negedge clk);
        chk("run5_sng", int'(sng_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_net_rst", int'(net_rst), 1);
        chk("abort_sng", int'(sng_en), 0);
        chk("abort_valid", int'(result_valid), 0);
        n_rv = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || busy) n_rv++;
        end
        chk("abort_no_result", n_rv, 0);
        run_pass(tbl[0], 20);
        // reset asserted during ARGMAX
        mode = 0;
        cls_sel = 3;
        jj = 0;
        len = LW'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("argmax_busy", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state();
        reset = 1'b1;
        n_rv = 0;
        repeat (30) begin
            @(negedge clk);
            if (result_valid || busy) n_rv++;
        end
        chk("reset_no_result", n_rv, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sc_inference_ctrl.md
Name: sc_inference_ctrl

Overview:
- Sequencer for one stochastic-computing MNIST inference pass.
- Resets the network datapath and enables the upstream stream generators for a programmed bitstream length.
- Accumulates the N2 output bitstreams into per-class popcounts, then selects the winning class by sequential argmax.
- Sits between the host/bus interface and the network instance. Drives the network's active-high reset and the SNG enable, and consumes the network's dout.

Parameters:
- N2, 10, number of output classes (width of net_dout).
- LMAX, 1024, maximum bitstream length.
- LW, 11, width of the len input; must satisfy 2^LW > LMAX.
- CW, 11, per-class counter width; must satisfy 2^CW > LMAX.
- PIPE_LAT, 2, cycles from sng_en first asserted to first valid bit on net_dout.
- IW, 4, class index width; IW = $clog2(N2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request an inference pass; accepted only in IDLE.
- len  in  LW  bitstream length; sampled on the accepted start.
- abort  in  1  cancel the current pass.
- busy  out  1  high in every state except IDLE.
- net_rst  out  1  active-high reset to the network and SNGs.
- sng_en  out  1  stream generator enable.
- net_dout  in  N2  network output bits, one per class per cycle.
- result_class  out  IW  index of the winning class.
- result_score  out  CW  popcount of the winning class.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All counters clear to 0.
  - Outputs: busy=0, sng_en=0, result_valid=0, result_class=0, result_score=0, net_rst=1.
- IDLE:
  - net_rst=1, sng_en=0.
  - start=1 latches len_q = min(len, LMAX) and moves to CLEAR.
- CLEAR, 1 cycle:
  - net_rst=1; all N2 counters and the cycle counter clear.
  - Next state is RUN, or ARGMAX if len_q==0.
- RUN, len_q+PIPE_LAT cycles:
  - net_rst=0, sng_en=1 for exactly the first len_q cycles, then 0.
  - Counting is enabled for cycle indices PIPE_LAT .. PIPE_LAT+len_q-1. In those cycles, counter[k] increments when net_dout[k]==1.
  - Counters saturate at 2^CW-1.
  - The last RUN cycle goes to ARGMAX.
- ARGMAX, exactly N2 cycles:
  - Index i steps 0..N2-1.
  - Cycle 0 loads best = counter[0], best_idx = 0.
  - Later cycles replace best only if counter[i] > best (strict). Ties resolve to the lowest index.
  - net_rst=1 throughout. The last cycle goes to DONE.
- DONE:
  - result_valid=1; result_class and result_score are held stable.
  - When result_valid && result_ready at an edge, move to IDLE; result_valid drops the next cycle.
  - Result registers keep their values until the next pass enters DONE.
- Abort:
  - abort=1 in CLEAR, RUN or ARGMAX moves to IDLE on the next edge, with sng_en=0 and net_rst=1.
  - No result is produced and result_valid stays 0.
  - abort is ignored in IDLE and DONE.
- Priority: reset > abort > normal transition.
- start is ignored while busy=1.
- Latency: result_valid rises 1+len_q+PIPE_LAT+N2 cycles after the edge that accepted start.
- len_q==0: RUN is skipped. result_class=0, result_score=0; latency is 1+N2.
- Reset asserted mid-pass returns to IDLE and discards the pass.

Optional Feature:
- Macro name: SC_CTRL_SCORE_OUT_EN.
- When defined:
  - Adds output port score_flat, width N2*CW; bits [k*CW +: CW] = counter[k].
  - score_flat is registered and updated together with result_class on entry to DONE.
  - It is 0 after reset.
- When undefined: the port is absent and the counters stay internal. All other behaviour is identical.

Test Plan:
- Basic pass. Stimulus: PIPE_LAT=2, start with len=16; net_dout model drives class 3 high every valid cycle and others low. Response: result_valid rises 29 cycles after start; result_class=3, result_score=16; sng_en high for exactly 16 cycles.
- Tie-break. Stimulus: classes 2 and 7 each high in 8 of 16 valid cycles. Response: result_class=2, result_score=8.
- Clamp and saturate. Stimulus: len=2047, all net_dout high. Response: len_q=1024; sng_en high for 1024 cycles; result_score=1024; result_class=0.
- Zero length. Stimulus: len=0. Response: sng_en never asserts; result_valid after 11 cycles; result_class=0, result_score=0.
- Abort and handshake. Stimulus: abort in RUN cycle 5. Response: IDLE next edge, busy=0, net_rst=1, no result_valid. Then run a normal pass with result_ready held low 20 cycles. Response: result_valid and the outputs stay stable; start is ignored meanwhile; IDLE one cycle after ready.
- Reset mid-pass and macro check. Stimulus: reset low during ARGMAX. Response: all outputs at reset values next edge. With SC_CTRL_SCORE_OUT_EN defined, the basic pass shows score_flat slice 3 = 16 and all other slices 0.
